// File: rtl/wb_exc_ctrl.sv
// Writeback-stage exception/interrupt arbiter feeding the CSR file, with a flush FSM
// that stalls WB until the front end acknowledges the redirect. Optional IDLE state: WB_EXC_IDLE_EN.
module wb_exc_ctrl #(
  parameter int unsigned FLUSH_MIN = 2,
  parameter logic [5:0]  INT_CODE  = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc,
  input  logic [5:0]  wb_excode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_badv,
  input  logic        wb_ertn,
  input  logic        wb_refetch,
  input  logic        wb_idle,
  input  logic [11:0] lie,
  input  logic [11:0] is,
  input  logic        ie,
  input  logic        redirect_ack,
  output logic        is_exc,
  output logic [5:0]  excode,
  output logic [8:0]  esubcode,
  output logic [31:0] badvaddr,
  output logic [31:0] csr_pc,
  output logic        is_ertn,
  output logic        is_fetch_again,
  output logic        wb_commit,
  output logic        wb_ready,
  output logic        flush
);

  localparam int unsigned CW = (FLUSH_MIN < 2) ? 1 : $clog2(FLUSH_MIN + 1);

`ifdef WB_EXC_IDLE_EN
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_IDLE} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_FLUSH} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ack_q, ack_nxt;
  logic          int_pend;
  logic          enter_flush;
  logic [31:0]   pc_plus4;

  assign int_pend = (|(lie & is)) & ie;
  assign pc_plus4 = wb_pc + 32'd4;

`ifdef WB_EXC_IDLE_EN
  logic [31:0] idle_pc, idle_pc_nxt;
  logic        wake;
  assign wake = |(lie & is);
`else
  logic unused_idle;
  assign unused_idle = wb_idle;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= '0;
      ack_q <= 1'b0;
`ifdef WB_EXC_IDLE_EN
      idle_pc <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack_q <= ack_nxt;
`ifdef WB_EXC_IDLE_EN
      idle_pc <= idle_pc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ack_nxt        = ack_q;
    enter_flush    = 1'b0;
    is_exc         = 1'b0;
    excode         = '0;
    esubcode       = '0;
    badvaddr       = '0;
    csr_pc         = '0;
    is_ertn        = 1'b0;
    is_fetch_again = 1'b0;
    wb_commit      = 1'b0;
    wb_ready       = 1'b0;
    flush          = 1'b0;
`ifdef WB_EXC_IDLE_EN
    idle_pc_nxt    = idle_pc;
`endif

    case (state)
      S_RUN: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          if (int_pend) begin
            is_exc      = 1'b1;
            excode      = INT_CODE;
            csr_pc      = wb_pc;
            enter_flush = 1'b1;
          end else if (wb_exc) begin
            is_exc      = 1'b1;
            excode      = wb_excode;
            esubcode    = wb_esubcode;
            badvaddr    = wb_badv;
            csr_pc      = wb_pc;
            enter_flush = 1'b1;
          end else if (wb_ertn) begin
            is_ertn     = 1'b1;
            wb_commit   = 1'b1;
            enter_flush = 1'b1;
          end else if (wb_refetch) begin
            is_fetch_again = 1'b1;
            csr_pc         = pc_plus4;
            wb_commit      = 1'b1;
            enter_flush    = 1'b1;
`ifdef WB_EXC_IDLE_EN
          end else if (wb_idle) begin
            wb_commit   = 1'b1;
            idle_pc_nxt = pc_plus4;
            state_nxt   = S_IDLE;
`endif
          end else begin
            wb_commit = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        // Exit needs both the minimum dwell and an ack (a same-cycle ack counts).
        flush   = 1'b1;
        ack_nxt = ack_q | redirect_ack;
        if (cnt > CW'(1)) begin
          cnt_nxt = cnt - CW'(1);
        end
        if ((cnt <= CW'(1)) && (ack_q || redirect_ack)) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          ack_nxt   = 1'b0;
        end
      end

`ifdef WB_EXC_IDLE_EN
      S_IDLE: begin
        if (wake) begin
          if (ie) begin
            is_exc = 1'b1;
            excode = INT_CODE;
          end else begin
            is_fetch_again = 1'b1;
          end
          csr_pc      = idle_pc;
          enter_flush = 1'b1;
        end
      end
`endif

      default: begin
        state_nxt = S_RUN;
      end
    endcase

    // Every event cycle flushes and arms the dwell counter and ack latch.
    if (enter_flush) begin
      flush     = 1'b1;
      state_nxt = S_FLUSH;
      cnt_nxt   = CW'(FLUSH_MIN);
      ack_nxt   = redirect_ack;
    end
  end

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Scoreboard bench for wb_exc_ctrl: expected per-cycle outputs are queued as stimulus
// is driven and compared on the following falling edge.
module tb_wb_exc_ctrl;

  logic        clk, reset;
  logic        wb_valid, wb_exc, wb_ertn, wb_refetch, wb_idle, ie, redirect_ack;
  logic [31:0] wb_pc, wb_badv;
  logic [5:0]  wb_excode;
  logic [8:0]  wb_esubcode;
  logic [11:0] lie, is;
  logic        is_exc, is_ertn, is_fetch_again, wb_commit, wb_ready, flush;
  logic [5:0]  excode;
  logic [8:0]  esubcode;
  logic [31:0] badvaddr, csr_pc;

  typedef struct packed {
    logic        is_exc;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr;
    logic [31:0] csr_pc;
    logic        is_ertn;
    logic        is_fetch_again;
    logic        wb_commit;
    logic        wb_ready;
    logic        flush;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  string       phase = "reset";

  wb_exc_ctrl #(.FLUSH_MIN(2), .INT_CODE(6'h00)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
    .wb_excode(wb_excode), .wb_esubcode(wb_esubcode), .wb_badv(wb_badv),
    .wb_ertn(wb_ertn), .wb_refetch(wb_refetch), .wb_idle(wb_idle),
    .lie(lie), .is(is), .ie(ie), .redirect_ack(redirect_ack),
    .is_exc(is_exc), .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr),
    .csr_pc(csr_pc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again),
    .wb_commit(wb_commit), .wb_ready(wb_ready), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val("is_exc",         32'(is_exc),         32'(e.is_exc));
      check_val("excode",         32'(excode),         32'(e.excode));
      check_val("esubcode",       32'(esubcode),       32'(e.esubcode));
      check_val("badvaddr",       badvaddr,            e.badvaddr);
      check_val("csr_pc",         csr_pc,              e.csr_pc);
      check_val("is_ertn",        32'(is_ertn),        32'(e.is_ertn));
      check_val("is_fetch_again", 32'(is_fetch_again), 32'(e.is_fetch_again));
      check_val("wb_commit",      32'(wb_commit),      32'(e.wb_commit));
      check_val("wb_ready",       32'(wb_ready),       32'(e.wb_ready));
      check_val("flush",          32'(flush),          32'(e.flush));
    end
  end

  function automatic exp_t e_run(input logic commit);
    exp_t e = '0;
    e.wb_ready  = 1'b1;
    e.wb_commit = commit;
    return e;
  endfunction

  function automatic exp_t e_flush();
    exp_t e = '0;
    e.flush = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_exc(input logic [5:0] code, input logic [8:0] sub,
                                 input logic [31:0] bad, input logic [31:0] pc);
    exp_t e = '0;
    e.is_exc   = 1'b1;
    e.excode   = code;
    e.esubcode = sub;
    e.badvaddr = bad;
    e.csr_pc   = pc;
    e.wb_ready = 1'b1;
    e.flush    = 1'b1;
    return e;
  endfunction

  task automatic clear_in();
    wb_valid = 0; wb_pc = '0; wb_exc = 0; wb_excode = '0; wb_esubcode = '0; wb_badv = '0;
    wb_ertn = 0; wb_refetch = 0; wb_idle = 0; lie = '0; is = '0; ie = 0; redirect_ack = 0;
  endtask

  task automatic cyc(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic skip();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    cyc(e_run(0));
    reset = 1'b0;
    repeat (3) cyc(e_run(0));

    phase = "int_no_valid";
    lie = 12'h800; is = 12'h800; ie = 1;
    repeat (2) cyc(e_run(0));
    clear_in();

    phase = "exc";
    wb_valid = 1; wb_pc = 32'h1C000100; wb_exc = 1; wb_excode = 6'h0B;
    wb_esubcode = 9'h1A5; wb_badv = 32'hDEAD0000;
    cyc(e_exc(6'h0B, 9'h1A5, 32'hDEAD0000, 32'h1C000100));
    clear_in();
    repeat (2) cyc(e_flush());
    wb_valid = 1; wb_pc = 32'h1C000104; lie = 12'h800; is = 12'h800; ie = 1;
    cyc(e_flush());
    clear_in();
    cyc(e_flush());
    redirect_ack = 1;
    cyc(e_flush());
    clear_in();
    cyc(e_run(0));

    phase = "int_vs_exc";
    lie = 12'h800; is = 12'h800; ie = 1; wb_valid = 1; wb_pc = 32'h1C000300;
    wb_exc = 1; wb_excode = 6'h0B; wb_esubcode = 9'h003; wb_badv = 32'h00001234;
    redirect_ack = 1;
    cyc(e_exc(6'h00, 9'h000, 32'h0, 32'h1C000300));
    clear_in();
    repeat (2) cyc(e_flush());
    cyc(e_run(0));

    phase = "int_masked";
    lie = 12'h800; is = 12'h800; ie = 0; wb_valid = 1; wb_pc = 32'h1C000310;
    cyc(e_run(1));
    clear_in();

    phase = "exc_vs_ertn";
    wb_valid = 1; wb_pc = 32'h1C000400; wb_exc = 1; wb_ertn = 1; wb_excode = 6'h08;
    cyc(e_exc(6'h08, 9'h000, 32'h0, 32'h1C000400));
    clear_in();
    redirect_ack = 1;
    cyc(e_flush());
    redirect_ack = 0;
    cyc(e_flush());
    cyc(e_run(0));

    phase = "ertn";
    wb_valid = 1; wb_pc = 32'h1C000500; wb_ertn = 1; redirect_ack = 1;
    e = e_run(1); e.is_ertn = 1; e.flush = 1;
    cyc(e);
    clear_in();
    repeat (2) cyc(e_flush());
    cyc(e_run(0));

    phase = "refetch_wrap";
    wb_valid = 1; wb_pc = 32'hFFFFFFFC; wb_refetch = 1; redirect_ack = 1;
    e = e_run(1); e.is_fetch_again = 1; e.csr_pc = 32'h0; e.flush = 1;
    cyc(e);
    clear_in();
    repeat (2) cyc(e_flush());
    cyc(e_run(0));

    phase = "normal";
    wb_valid = 1; wb_pc = 32'h1C000600;
    cyc(e_run(1));
    wb_pc = 32'h1C000604;
    cyc(e_run(1));
    clear_in();

`ifdef WB_EXC_IDLE_EN
    phase = "idle_fetch";
    wb_valid = 1; wb_pc = 32'h1C000200; wb_idle = 1;
    cyc(e_run(1));
    clear_in();
    repeat (10) cyc('0);
    lie = 12'h004; is = 12'h004; ie = 0; redirect_ack = 1;
    e = '0; e.is_fetch_again = 1; e.csr_pc = 32'h1C000204; e.flush = 1;
    cyc(e);
    clear_in();
    repeat (2) cyc(e_flush());
    cyc(e_run(0));

    phase = "idle_int";
    wb_valid = 1; wb_pc = 32'h1C000700; wb_idle = 1;
    cyc(e_run(1));
    clear_in();
    repeat (2) cyc('0);
    lie = 12'h002; is = 12'h002; ie = 1; redirect_ack = 1;
    e = '0; e.is_exc = 1; e.excode = 6'h00; e.csr_pc = 32'h1C000704; e.flush = 1;
    cyc(e);
    clear_in();
    repeat (2) cyc(e_flush());
    cyc(e_run(0));

    phase = "idle_reset";
    wb_valid = 1; wb_pc = 32'h1C000800; wb_idle = 1;
    cyc(e_run(1));
    clear_in();
    cyc('0);
    reset = 1;
    skip();
    reset = 0;
    cyc(e_run(0));
`else
    phase = "idle_ignored";
    wb_valid = 1; wb_pc = 32'h1C000200; wb_idle = 1;
    cyc(e_run(1));
    clear_in();
    cyc(e_run(0));
`endif

    phase = "flush_reset";
    wb_valid = 1; wb_pc = 32'h1C000900; wb_exc = 1; wb_excode = 6'h01;
    cyc(e_exc(6'h01, 9'h000, 32'h0, 32'h1C000900));
    clear_in();
    cyc(e_flush());
    reset = 1;
    skip();
    reset = 0;
    repeat (2) cyc(e_run(0));

    phase = "after_reset";
    wb_valid = 1; wb_pc = 32'h1C000A00; wb_exc = 1; wb_excode = 6'h02; redirect_ack = 1;
    cyc(e_exc(6'h02, 9'h000, 32'h0, 32'h1C000A00));
    clear_in();
    repeat (2) cyc(e_flush());
    cyc(e_run(0));

    phase = "end";
    @(negedge clk);
    check_val("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
